pe_ld_unit: RTL
===============

PE_LD_UNIT -- requirements
Module: pe_ld_unit

Interface
REQ-001 SHALL have parameter ADDR_L, default GLOBAL_MEM_ADDR_L (23), meaning the load-stream address width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default MAX_OUTSTANDING_LD_REQ (4), meaning the maximum number of in-flight global reads.
REQ-003 SHALL have parameter FIFO_DEPTH, default LD_DATA_FIFO_DEPTH (16), meaning the return-data FIFO entries.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port len_vld, input, 1, pulse that loads the stream length (SET_LD_STREAM_LEN instr).
REQ-007 SHALL have port len, input, LD_STREAM_CNT_L (15), the number of loads in the stream.
REQ-008 SHALL have ports str_word / str_vld / str_rdy: input ADDR_L+REG_ADDR_L (28) / input 1 / output 1; the load-stream word {addr, dest_reg}, with dest_reg in the LSBs.
REQ-009 SHALL have ports gl_req / gl_addr / gl_gnt: output 1 / output ADDR_L / input 1; the global-memory read request.
REQ-010 SHALL have ports gl_rdata / gl_rvld: input DATA_L / input 1; global read return, in grant order.
REQ-011 SHALL have ports lc_rd_en / lc_addr / lc_rdata: output 1 / output LOCAL_MEM_ADDR_L (16) / input DATA_L; local memory with LOCAL_MEM_RD_LATENCY=1.
REQ-012 SHALL have ports out_vld / out_data / out_reg / out_rdy: output 1 / output DATA_L / output REG_ADDR_L / input 1; load results toward the regbank.
REQ-013 SHALL have port busy, output, 1, high while a stream is active or any data is undelivered.
REQ-014 SHALL have port stall_cnt, output, 16, the perf counter (see Configuration).

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE on len_vld with len>0; ISSUE -> DRAIN when the remaining count reaches 0; DRAIN -> IDLE when outstanding==0 and the FIFO is empty.
REQ-016 SHALL ignore len_vld outside IDLE, and SHALL stay in IDLE when len==0.
REQ-017 SHALL route a word to local memory when addr[LOCAL_MEM_INDICATOR_S]==LOCAL_MEM_INDICATOR (0), with lc_addr=addr[15:0]; otherwise it goes to global.
REQ-018 SHALL accept a word (str_rdy=1) only in ISSUE, with remaining>0, and only when a request slot is free: outstanding+fifo_count+lc_pending < FIFO_DEPTH.
REQ-019 SHALL, for a global word, additionally require outstanding < MAX_OUTSTANDING, hold gl_req/gl_addr stable until gl_gnt, and accept no new word while gl_req is waiting for its grant.
REQ-020 SHALL, for a local word, additionally require outstanding==0 (program order preserved); it asserts lc_rd_en for 1 cycle and writes lc_rdata to the FIFO the next cycle.
REQ-021 SHALL store dest_reg in a 4-entry tag queue at gl_gnt and pop it on gl_rvld, pairing each gl_rdata with its dest_reg.
REQ-022 SHALL decrement remaining on each accepted word.
REQ-023 SHALL keep outstanding at +1 on gl_gnt and -1 on gl_rvld, net 0 when both occur in the same cycle.
REQ-024 SHALL drive out_vld whenever the FIFO is non-empty (first-word fall-through); an entry pops on out_vld&&out_rdy.
REQ-025 SHALL support a simultaneous FIFO push and pop in one cycle, including when the FIFO is full.
REQ-026 SHALL treat gl_rvld with outstanding==0 as an error and drop it (assertion in simulation).
REQ-027 SHALL keep the FIFO and tag queue write/read pointers wrapping modulo depth, with full/empty derived from a count register.

Reset
REQ-028 SHALL, on rst, set state=IDLE and clear remaining, outstanding, FIFO/tag pointers, counts and stall_cnt.
REQ-029 SHALL hold all outputs at 0 during reset and in the cycle after it.
REQ-030 SHALL, on rst mid-stream, abandon in-flight reads and ignore their returns that arrive after reset.

Configuration
REQ-031 SHALL, with PE_LD_STALL_CNT_EN defined, increment stall_cnt (saturating at 0xFFFF) each ISSUE cycle with str_vld=1 and str_rdy=0.
REQ-032 SHALL, without PE_LD_STALL_CNT_EN, tie stall_cnt to 0 and synthesize no counter logic.

Verification
REQ-033 SHALL cover: len=3, three global words, gl_gnt same cycle, gl_rvld 2 cycles later -> 3 outputs in order with matching regs; busy falls 1 cycle after the last pop.
REQ-034 SHALL cover: gl_rvld withheld, 6 global words -> exactly 4 grants, then str_rdy=0; each return releases one more.
REQ-035 SHALL cover: global, local, global words (addr MSB 1,0,1) -> the local is issued only after the first global returns; output order is preserved.
REQ-036 SHALL cover: out_rdy=0, len=20 local words -> 16 accepted, then stall; with PE_LD_STALL_CNT_EN, stall_cnt counts the blocked cycles.
REQ-037 SHALL cover: rst after 2 of 5 grants -> outputs 0, state IDLE, late gl_rvld ignored.
REQ-038 SHALL cover: len_vld with len=0, and len_vld during ISSUE -> no state change.

Source files
------------

// File: rtl/pe_ld_unit_if.sv
// Load-unit bus bundle: load-stream input, global read port, local read port
// and the result stream toward the register bank.
// master = the load unit, slave = its environment.
interface pe_ld_unit_if #(
  parameter int ADDR_L     = 23,
  parameter int REG_ADDR_L = 5,
  parameter int DATA_L     = 32,
  parameter int LC_ADDR_L  = 16
);
  logic [ADDR_L+REG_ADDR_L-1:0] str_word;
  logic                         str_vld;
  logic                         str_rdy;
  logic                         gl_req;
  logic [ADDR_L-1:0]            gl_addr;
  logic                         gl_gnt;
  logic [DATA_L-1:0]            gl_rdata;
  logic                         gl_rvld;
  logic                         lc_rd_en;
  logic [LC_ADDR_L-1:0]         lc_addr;
  logic [DATA_L-1:0]            lc_rdata;
  logic                         out_vld;
  logic [DATA_L-1:0]            out_data;
  logic [REG_ADDR_L-1:0]        out_reg;
  logic                         out_rdy;

  modport master (
    input  str_word, str_vld, gl_gnt, gl_rdata, gl_rvld, lc_rdata, out_rdy,
    output str_rdy, gl_req, gl_addr, lc_rd_en, lc_addr, out_vld, out_data, out_reg
  );

  modport slave (
    output str_word, str_vld, gl_gnt, gl_rdata, gl_rvld, lc_rdata, out_rdy,
    input  str_rdy, gl_req, gl_addr, lc_rd_en, lc_addr, out_vld, out_data, out_reg
  );
endinterface

// File: rtl/pe_ld_unit.sv
// PE load unit: consumes a stream of {addr, dest_reg} words, issues each to
// global memory (in-order returns, up to MAX_OUTSTANDING in flight) or to
// local memory (1-cycle latency), and delivers results in program order
// through a fall-through FIFO.
// Optional feature: define PE_LD_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to 0.
module pe_ld_unit #(
  parameter int ADDR_L          = 23,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         len_vld,
  input  logic [14:0]  len,
  pe_ld_unit_if.master bus,
  output logic         busy,
  output logic [15:0]  stall_cnt
);
  localparam int   REG_ADDR_L = 5;
  localparam int   DATA_L     = 32;
  localparam int   LC_IND_S   = ADDR_L - 1;
  localparam logic LC_IND     = 1'b0;
  localparam int   OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int   CW  = $clog2(FIFO_DEPTH + 1);
  localparam int   SW  = CW + 1;
  localparam int   FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int   TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int   EW  = REG_ADDR_L + DATA_L;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state;
  logic [14:0]           remaining;
  logic [OW-1:0]         outstanding;
  logic                  gl_req_q;
  logic [ADDR_L-1:0]     gl_addr_q;
  logic [REG_ADDR_L-1:0] gl_tag;
  logic                  lc_pending;
  logic [REG_ADDR_L-1:0] lc_reg_q;

  logic [REG_ADDR_L-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TPW-1:0]        tag_wr, tag_rd;

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0]        fifo_wr, fifo_rd;
  logic [CW-1:0]         fifo_cnt;

  logic [ADDR_L-1:0]     word_addr;
  logic [REG_ADDR_L-1:0] word_reg;
  logic                  is_local, slot_free, can_take, accept, acc_gl, acc_lc;
  logic                  gnt, rvld_ok, push, pop;
  logic [SW-1:0]         slot_used;
  logic [DATA_L-1:0]     push_data;
  logic [REG_ADDR_L-1:0] push_reg;
  logic [EW-1:0]         head;

  assign word_addr = bus.str_word[REG_ADDR_L +: ADDR_L];
  assign word_reg  = bus.str_word[REG_ADDR_L-1:0];
  assign is_local  = (word_addr[LC_IND_S] == LC_IND);

  // Every accepted word owns a FIFO slot from issue until it is delivered,
  // so returning data can always be pushed without back-pressure.
  assign slot_used = SW'(fifo_cnt) + SW'(outstanding) + SW'(lc_pending);
  assign slot_free = (slot_used < SW'(FIFO_DEPTH));

  // A local read may only go out once all earlier global reads are back,
  // which keeps results in program order through a single FIFO.
  assign can_take = (state == S_ISSUE) && (remaining != '0) && !gl_req_q && slot_free &&
                    (is_local ? (outstanding == '0) : (outstanding < OW'(MAX_OUTSTANDING)));
  assign accept   = !rst && bus.str_vld && can_take;
  assign acc_gl   = accept && !is_local;
  assign acc_lc   = accept && is_local;

  assign gnt       = gl_req_q && bus.gl_gnt;
  assign rvld_ok   = bus.gl_rvld && (outstanding != '0);
  assign push      = rvld_ok || lc_pending;
  assign push_data = lc_pending ? bus.lc_rdata : bus.gl_rdata;
  assign push_reg  = lc_pending ? lc_reg_q : tag_mem[tag_rd];
  assign pop       = (fifo_cnt != '0) && bus.out_rdy;
  assign head      = fifo_mem[fifo_rd];

  assign bus.str_rdy  = !rst && can_take;
  assign bus.gl_req   = !rst && gl_req_q;
  assign bus.gl_addr  = rst ? '0 : gl_addr_q;
  assign bus.lc_rd_en = acc_lc;
  assign bus.lc_addr  = acc_lc ? word_addr[15:0] : '0;
  assign bus.out_vld  = !rst && (fifo_cnt != '0);
  assign bus.out_data = bus.out_vld ? head[DATA_L-1:0] : '0;
  assign bus.out_reg  = bus.out_vld ? head[EW-1:DATA_L] : '0;
  assign busy         = !rst && ((state != S_IDLE) || (fifo_cnt != '0));

  // Stream FSM, request issue and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      outstanding <= '0;
      gl_req_q    <= 1'b0;
      gl_addr_q   <= '0;
      gl_tag      <= '0;
      lc_pending  <= 1'b0;
      lc_reg_q    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (len_vld && len != '0) begin
          remaining <= len;
          state     <= S_ISSUE;
        end
        S_ISSUE: if (accept) begin
          remaining <= remaining - 1'b1;
          if (remaining == 15'd1) state <= S_DRAIN;
        end
        S_DRAIN: if (outstanding == '0 && fifo_cnt == '0 && !gl_req_q && !lc_pending)
          state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (acc_gl) begin
        gl_req_q  <= 1'b1;
        gl_addr_q <= word_addr;
        gl_tag    <= word_reg;
      end else if (gnt) begin
        gl_req_q  <= 1'b0;
      end

      lc_pending <= acc_lc;
      if (acc_lc) lc_reg_q <= word_reg;

      case ({gnt, rvld_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (gnt)     tag_wr  <= (tag_wr == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + 1'b1;
      if (rvld_ok) tag_rd  <= (tag_rd == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + 1'b1;
      if (push)    fifo_wr <= (fifo_wr == FPW'(FIFO_DEPTH - 1)) ? '0 : fifo_wr + 1'b1;
      if (pop)     fifo_rd <= (fifo_rd == FPW'(FIFO_DEPTH - 1)) ? '0 : fifo_rd + 1'b1;

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage arrays: tag queue written at grant, data FIFO written on return.
  always_ff @(posedge clk) begin
    if (gnt)  tag_mem[tag_wr]   <= gl_tag;
    if (push) fifo_mem[fifo_wr] <= {push_reg, push_data};
  end

`ifdef PE_LD_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of issue cycles where a word was offered but refused.
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (state == S_ISSUE && bus.str_vld && !can_take && stall_q != 16'hFFFF)
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = rst ? '0 : stall_q;
`else
  assign stall_cnt = '0;
`endif

  // A return with nothing in flight during a stream is a protocol error; it
  // is dropped. Returns while idle are leftovers abandoned by a reset.
  a_no_stray_rvld: assert property (@(posedge clk) disable iff (rst)
    !(bus.gl_rvld && outstanding == '0 && state != S_IDLE));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
  a_one_push: assert property (@(posedge clk) disable iff (rst)
    !(rvld_ok && lc_pending));
endmodule
